// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic-unit types and default sizes
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } arith_state_t;

  localparam int ARITH_WIDTH = 8;
  localparam int ARITH_CNT_W = 4;

endpackage

// File: rtl/seq_mult_datapath.sv
// rtl/seq_mult_datapath.sv - shift-add multiplier registers, WIDTH+1 adder and shifter
module seq_mult_datapath
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] mplr_next
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   sum;

  // The adder carry lands in the acc MSB; the sum LSB moves into the mplr MSB.
  always_comb begin
    sum                   = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : '0);
    {acc_next, mplr_next} = {sum, mplr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      mplr  <= '0;
      mcand <= '0;
    end else if (load) begin
      acc   <= '0;
      mplr  <= multiplier;
      mcand <= multiplicand;
    end else if (step) begin
      acc   <= acc_next;
      mplr  <= mplr_next;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - sequential shift-add unsigned multiplier, start/valid handshake
// Optional early exit on exhausted multiplier bits: SEQ_MULT_EARLY_EXIT_EN
module seq_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH,
  parameter int CNT_W = ARITH_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               valid,
  output logic               busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  arith_state_t       state;
  logic [CNT_W-1:0]   cnt;
  logic               load;
  logic               step;
  logic               finish;
  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   mplr_next;
  logic [2*WIDTH-1:0] result;

  seq_mult_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .step        (step),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .acc_next    (acc_next),
    .mplr_next   (mplr_next)
  );

`ifdef SEQ_MULT_EARLY_EXIT_EN
  logic [CNT_W-1:0] done_cnt;
  logic [CNT_W-1:0] remaining;
  logic             rest_zero;

  // Once the unprocessed multiplier bits are zero, the partial product is final
  // but still left-shifted by the iterations that were skipped.
  always_comb begin
    load      = (state == IDLE) && start;
    step      = (state == CALC);
    done_cnt  = cnt + CNT_W'(1);
    remaining = CNT_W'(WIDTH) - done_cnt;
    rest_zero = ((mplr_next << done_cnt) == '0);
    finish    = step && ((cnt == LAST_CNT) || rest_zero);
    result    = {acc_next, mplr_next} >> remaining;
  end
`else
  always_comb begin
    load   = (state == IDLE) && start;
    step   = (state == CALC);
    finish = step && (cnt == LAST_CNT);
    result = {acc_next, mplr_next};
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      product <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (finish) begin
            product <= result;
            valid   <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Sequential shift-add unsigned multiplier. It is the inverse-operation companion to the restoring-divider controller and uses the same start/valid handshake.
- Integer-arithmetic datapath plus control FSM in one block. A host strobes operands in, and the block returns a double-width product after a fixed number of iterations.
- Sits beside the divider in the arithmetic unit. The host side of the interface is shared.

Parameters:
- WIDTH, 8: operand width in bits. The product is 2*WIDTH bits.
- CNT_W, 4: iteration-counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request strobe; sampled only in IDLE
- multiplicand  input  WIDTH  operand A; captured on accepted start
- multiplier  input  WIDTH  operand B; captured on accepted start
- product  output  2*WIDTH  result; held until the next completion
- valid  output  1  one-cycle pulse when product is updated
- busy  output  1  high from the cycle after an accepted start through the DONE cycle

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; accumulator, multiplier shift register, multiplicand register and counter all cleared.
  - Outputs: product=0, valid=0, busy=0.
  - Asserting reset mid-operation aborts the operation. No valid is issued, and the next start after release begins a fresh operation.
- FSM states: IDLE, CALC, DONE.
  - IDLE: if start=1 at the edge, capture mcand<=multiplicand, mplr<=multiplier, acc<=0, cnt<=0, and go to CALC. Otherwise stay in IDLE.
  - CALC: one iteration per edge:
    - sum = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : 0), computed WIDTH+1 bits wide so the carry is kept.
    - {acc, mplr} <= {sum, mplr} >> 1, i.e. carry into acc MSB and sum LSB into mplr MSB.
    - cnt <= cnt+1.
    - When cnt==WIDTH-1 at the edge, go to DONE and load product<={final acc, final mplr}.
  - DONE: valid=1 for exactly this one cycle, then go to IDLE unconditionally.
- Outputs:
  - valid is registered and high only in DONE.
  - busy=1 in CALC and DONE.
- Latency:
  - start sampled at edge 0, WIDTH iterations at edges 1..WIDTH, valid high in the cycle following edge WIDTH.
  - Start-to-valid is WIDTH+1 cycles (9 for WIDTH=8). The earliest next accepted start is WIDTH+2 edges after the previous one.
- Handshake:
  - start is ignored in CALC and DONE; there is no queueing and no error flag.
  - Operand inputs are don't-care except at the accepting edge.
- Arithmetic:
  - Unsigned only. The result is exact, with no overflow possible in 2*WIDTH bits.
  - Max case 255*255 = 65025 = 16'hFE01.
- Boundaries:
  - Zero operand gives product 0 with full latency (unless the optional feature is enabled).
  - start held high continuously produces back-to-back operations spaced WIDTH+2 cycles apart.
  - product keeps its previous value during CALC.

Optional Feature:
- Macro SEQ_MULT_EARLY_EXIT_EN.
- Defined: in CALC, if the post-update multiplier bits still to be processed are all zero, the FSM goes to DONE immediately.
  - The product is formed by right-aligning acc/mplr to the full shift count; this is a combinational barrel alignment by the remaining count.
  - Latency = (index of the highest set multiplier bit + 1) + 1 cycles.
  - multiplier=0 gives valid 2 cycles after start.
- Undefined: fixed WIDTH+1 latency and no alignment logic.
- Product values are identical either way.

Decomposition:
- Shared package arith_pkg holds:
  - the FSM state enum: IDLE=2'b00, CALC=2'b01, DONE=2'b10;
  - default WIDTH and CNT_W constants, shared with the divider.
- Natural sub-module: seq_mult_datapath, containing the acc/mplr/mcand registers, the WIDTH+1 adder and the shifter, controlled by load/step strobes.
- The FSM and counter stay in the top module.

Test Plan:
- Reset, then start with 13*11 -> valid exactly 9 cycles later, product=16'd143, busy high for 9 cycles.
- Start with 255*255 -> product=16'hFE01; carry-out path exercised.
- Start with 0*200 and 200*0 -> product=0, valid at 9 cycles (or 2 cycles for multiplier=0 with SEQ_MULT_EARLY_EXIT_EN).
- Re-strobe start with different operands in CALC cycles 3 and 9 (DONE) -> ignored; product equals the first operands' result and only one valid pulse.
- Drive reset low at CALC iteration 4 -> product=0, valid never pulses, busy=0. After release, 7*9 -> 16'd63 at normal latency.
- start held high for 30 cycles with constant 100*3 -> valid pulses spaced 10 cycles apart, each with product=16'd300.
